// File: rtl/periph_pkg.sv
// Shared types and helpers for the peripheral bus arbiter and its pickers.
package periph_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   // Index width for n entries; never below one bit so a single entry still has a port.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? int'($clog2(n)) : 1;
   endfunction

endpackage

// File: rtl/periph_arbiter_rr_select.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_select
   import periph_pkg::*;
#(
   parameter  int unsigned N  = 2,
   localparam int unsigned IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid_c,
   output logic [IW-1:0] idx_c
);

   int unsigned cand;

   always_comb begin
      valid_c = 1'b0;
      idx_c   = '0;
      cand    = 0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = (32'(ptr) + i) % N;
         if (!valid_c && req[IW'(cand)]) begin
            valid_c = 1'b1;
            idx_c   = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/periph_arbiter.sv
// Round-robin owner of the peripheral bus; each access runs SETUP, STROBE_CYC strobe cycles, HOLD.
module periph_arbiter
   import periph_pkg::*;
#(
   parameter int unsigned N_REQ      = 2,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned STROBE_CYC = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_REQ-1:0]              req,
   input  logic [N_REQ-1:0]              req_we,
   input  logic [N_REQ-1:0][ADDR_W-1:0]  req_addr,
   input  logic [N_REQ-1:0][DATA_W-1:0]  req_wdata,
   output logic [N_REQ-1:0]              ack,
   output logic [DATA_W-1:0]             rdata,
   output logic                          bus_we,
   output logic                          bus_oe,
   output logic [ADDR_W-1:0]             periphbus_addr,
   inout  wire  [DATA_W-1:0]             bus_data
);

   localparam int unsigned IW = idx_w(N_REQ);
   localparam int unsigned CW = idx_w(STROBE_CYC);

   state_t            state;
   logic [IW-1:0]     grant;
   logic [IW-1:0]     ptr;
   logic              lat_we;
   logic [DATA_W-1:0] wdata_q;
   logic              drive;
   logic [CW-1:0]     cnt;
   logic              sel_valid_c;
   logic [IW-1:0]     sel_idx_c;

   rr_select #(.N(N_REQ)) u_rr (
      .req     (req),
      .ptr     (ptr),
      .valid_c (sel_valid_c),
      .idx_c   (sel_idx_c)
   );

   // Write data is driven from SETUP through HOLD so it brackets the strobe on both sides.
   assign bus_data = drive ? wdata_q : {DATA_W{1'bz}};

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         ack            <= '0;
         rdata          <= '0;
         bus_we         <= 1'b0;
         bus_oe         <= 1'b0;
         periphbus_addr <= '0;
         drive          <= 1'b0;
         ptr            <= '0;
         grant          <= '0;
         lat_we         <= 1'b0;
         wdata_q        <= '0;
         cnt            <= '0;
      end else begin
         ack <= '0;
         case (state)
            IDLE: begin
               if (sel_valid_c) begin
                  grant          <= sel_idx_c;
                  lat_we         <= req_we[sel_idx_c];
                  periphbus_addr <= req_addr[sel_idx_c];
                  wdata_q        <= req_wdata[sel_idx_c];
                  drive          <= req_we[sel_idx_c];
                  state          <= SETUP;
               end
            end
            SETUP: begin
               bus_we <= lat_we;
               bus_oe <= !lat_we;
               cnt    <= CW'(STROBE_CYC - 1);
               state  <= STROBE;
            end
            STROBE: begin
               if (cnt == '0) begin
                  bus_we     <= 1'b0;
                  bus_oe     <= 1'b0;
                  ack[grant] <= 1'b1;
                  if (!lat_we) rdata <= bus_data;
                  ptr        <= (grant == IW'(N_REQ - 1)) ? '0 : IW'(grant + 1'b1);
                  state      <= HOLD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HOLD: begin
               drive <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_periph_arbiter.sv
// Bench for periph_arbiter: two instances (STROBE_CYC 1 and 3) against a transaction-offset model.
module tb_periph_arbiter;

   localparam int unsigned N  = 2;
   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic [N-1:0]         req = '0;
   logic [N-1:0]         req_we = '0;
   logic [N-1:0][AW-1:0] req_addr = '0;
   logic [N-1:0][DW-1:0] req_wdata = '0;

   logic [N-1:0]  ack0, ack1;
   logic [DW-1:0] rdata0, rdata1;
   logic          we0, we1, oe0, oe1;
   logic [AW-1:0] addr0, addr1;
   wire  [DW-1:0] bd0, bd1;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int base = 0;
   bit armed = 1'b0;

   int ack_cyc0[$], ack_idx0[$], ack_cyc1[$], ack_idx1[$];

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] slave(input logic [AW-1:0] a);
      return DW'(a ^ 8'h3E);
   endfunction

   function automatic int sc(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   // Idle bus reads as all ones; the slave answers only while a read strobe is up.
   pullup pu0 (bd0);
   pullup pu1 (bd1);
   assign bd0 = oe0 ? slave(addr0) : {DW{1'bz}};
   assign bd1 = oe1 ? slave(addr1) : {DW{1'bz}};

   periph_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .STROBE_CYC(1)) u_dut0 (
      .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .ack(ack0), .rdata(rdata0), .bus_we(we0), .bus_oe(oe0),
      .periphbus_addr(addr0), .bus_data(bd0));

   periph_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .STROBE_CYC(3)) u_dut1 (
      .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .ack(ack1), .rdata(rdata1), .bus_we(we1), .bus_oe(oe1),
      .periphbus_addr(addr1), .bus_data(bd1));

   function automatic void chk(input string name, input int k, input logic [31:0] act,
                               input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
      end
   endfunction

   // Model: each instance is either idle or at cycle offset m_off of a transaction
   // (1 = SETUP, strobe for offsets 2..1+sc, ack at 2+sc, idle again at 3+sc).
   bit            m_busy [2];
   int            m_off  [2];
   int            m_g    [2];
   int            m_ptr  [2];
   bit            m_we   [2];
   logic [AW-1:0] m_addr [2];
   logic [DW-1:0] m_wd   [2];
   logic [DW-1:0] m_rd   [2];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) armed <= 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_busy[k] = 1'b0;
            m_ptr[k]  = 0;
            m_addr[k] = '0;
            m_rd[k]   = '0;
         end else if (m_busy[k]) begin
            m_off[k] = m_off[k] + 1;
            if (m_off[k] == 2 + sc(k)) begin
               m_ptr[k] = (m_g[k] + 1) % N;
               if (!m_we[k]) m_rd[k] = slave(m_addr[k]);
            end else if (m_off[k] == 3 + sc(k)) begin
               m_busy[k] = 1'b0;
            end
         end else begin
            for (int j = 0; j < N; j++) begin
               int c;
               c = (m_ptr[k] + j) % N;
               if (!m_busy[k] && req[c]) begin
                  m_busy[k] = 1'b1;
                  m_off[k]  = 1;
                  m_g[k]    = c;
                  m_we[k]   = req_we[c];
                  m_addr[k] = req_addr[c];
                  m_wd[k]   = req_wdata[c];
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         for (int k = 0; k < 2; k++) begin
            logic [N-1:0]  a, e_ack;
            logic          w, o, strobe;
            logic [AW-1:0] ad;
            logic [DW-1:0] rd, bd, e_bd;
            int            s;
            a  = (k == 0) ? ack0 : ack1;
            w  = (k == 0) ? we0 : we1;
            o  = (k == 0) ? oe0 : oe1;
            ad = (k == 0) ? addr0 : addr1;
            rd = (k == 0) ? rdata0 : rdata1;
            bd = (k == 0) ? bd0 : bd1;
            s  = sc(k);
            strobe = m_busy[k] && m_off[k] >= 2 && m_off[k] <= 1 + s;
            e_ack  = (m_busy[k] && m_off[k] == 2 + s) ? N'(1 << m_g[k]) : '0;
            if (m_busy[k] && m_we[k] && m_off[k] <= 2 + s) e_bd = m_wd[k];
            else if (strobe && !m_we[k])                   e_bd = slave(m_addr[k]);
            else                                           e_bd = '1;
            chk("bus_we", k, 32'(w), 32'(strobe && m_we[k]));
            chk("bus_oe", k, 32'(o), 32'(strobe && !m_we[k]));
            chk("ack", k, 32'(a), 32'(e_ack));
            chk("addr", k, 32'(ad), 32'(m_addr[k]));
            chk("bus_data", k, 32'(bd), 32'(e_bd));
            if (e_ack != '0 && !m_we[k]) chk("rdata", k, 32'(rd), 32'(m_rd[k]));
            if (a != '0) begin
               if (k == 0) begin ack_cyc0.push_back(cyc); ack_idx0.push_back(a[1] ? 1 : 0); end
               else        begin ack_cyc1.push_back(cyc); ack_idx1.push_back(a[1] ? 1 : 0); end
            end
         end
      end
   end

   task automatic start();
      @(negedge clk);
      base = cyc;
   endtask

   task automatic at_cyc(input int n);
      while (cyc < base + n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      ack_cyc0.delete(); ack_idx0.delete(); ack_cyc1.delete(); ack_idx1.delete();
   endtask

   task automatic clear_logs();
      ack_cyc0.delete(); ack_idx0.delete(); ack_cyc1.delete(); ack_idx1.delete();
   endtask

   initial begin
      // Reset then a quiet bus
      do_reset();
      start();
      chk("rst_rdata", 0, 32'(rdata0), 32'h0);
      for (int i = 0; i < 10; i++) begin
         at_cyc(i);
         chk("idle_strobes", 0, 32'({we0, oe0, we1, oe1}), 32'h0);
         chk("idle_ack", 0, 32'({ack0, ack1}), 32'h0);
         chk("idle_bus", 0, 32'(bd0), 32'hFF);
      end

      // Single write from requester 0
      start();
      req = 2'b01; req_we = 2'b01; req_addr[0] = 8'h05; req_wdata[0] = 8'hA5;
      at_cyc(1);
      req = '0;
      chk("wr_setup_addr", 0, 32'(addr0), 32'h05);
      chk("wr_setup_we", 0, 32'(we0), 32'h0);
      chk("wr_setup_bus", 0, 32'(bd0), 32'hA5);
      at_cyc(2);
      chk("wr_strobe_we", 0, 32'(we0), 32'h1);
      chk("wr_strobe_bus", 0, 32'(bd0), 32'hA5);
      at_cyc(3);
      chk("wr_hold_ack", 0, 32'(ack0), 32'h1);
      chk("wr_hold_we", 0, 32'(we0), 32'h0);
      chk("wr_hold_bus", 0, 32'(bd0), 32'hA5);
      at_cyc(4);
      chk("wr_idle_bus", 0, 32'(bd0), 32'hFF);
      chk("wr_idle_ack", 0, 32'(ack0), 32'h0);
      at_cyc(10);

      // Single read from requester 1
      start();
      req = 2'b10; req_we = 2'b00; req_addr[1] = 8'h02;
      at_cyc(1);
      req = '0;
      chk("rd_setup_bus", 0, 32'(bd0), 32'hFF);
      at_cyc(2);
      chk("rd_strobe_oe", 0, 32'(oe0), 32'h1);
      chk("rd_strobe_we", 0, 32'(we0), 32'h0);
      chk("rd_strobe_bus", 0, 32'(bd0), 32'h3C);
      at_cyc(3);
      chk("rd_hold_ack", 0, 32'(ack0), 32'h2);
      chk("rd_hold_rdata", 0, 32'(rdata0), 32'h3C);
      chk("rd_hold_bus", 0, 32'(bd0), 32'hFF);
      at_cyc(10);

      // Both requesters held continuously
      do_reset();
      start();
      req = 2'b11; req_we = 2'b11;
      req_addr[0] = 8'h10; req_addr[1] = 8'h11;
      req_wdata[0] = 8'h11; req_wdata[1] = 8'h22;
      at_cyc(26);
      req = '0;
      at_cyc(36);
      chk("rr_count0", 0, 32'(ack_cyc0.size() >= 4), 32'h1);
      chk("rr_count1", 1, 32'(ack_cyc1.size() >= 4), 32'h1);
      for (int i = 0; i < 4 && i < ack_cyc0.size(); i++) begin
         chk("rr_order", 0, 32'(ack_idx0[i]), 32'(i % 2));
         chk("rr_cycle", 0, 32'(ack_cyc0[i] - base), 32'(3 + 4 * i));
      end
      for (int i = 0; i < 4 && i < ack_cyc1.size(); i++) begin
         chk("rr_order", 1, 32'(ack_idx1[i]), 32'(i % 2));
         chk("rr_cycle", 1, 32'(ack_cyc1[i] - base), 32'(5 + 6 * i));
      end

      // Request dropped and address changed after grant
      do_reset();
      start();
      req = 2'b01; req_we = 2'b01; req_addr[0] = 8'h40; req_wdata[0] = 8'h5A;
      at_cyc(1);
      req_addr[0] = 8'h7F;
      at_cyc(2);
      req = '0;
      chk("drop_addr", 0, 32'(addr0), 32'h40);
      chk("drop_we", 0, 32'(we0), 32'h1);
      at_cyc(3);
      chk("drop_ack", 0, 32'(ack0), 32'h1);
      chk("drop_addr_hold", 0, 32'(addr0), 32'h40);
      at_cyc(10);

      // Reset while strobing aborts the access
      clear_logs();
      start();
      req = 2'b01; req_we = 2'b01; req_addr[0] = 8'h21; req_wdata[0] = 8'hC3;
      at_cyc(1);
      req = '0;
      at_cyc(2);
      chk("abort_pre_we", 0, 32'(we0), 32'h1);
      reset = 1'b1;
      at_cyc(3);
      chk("abort_we", 0, 32'({we0, we1}), 32'h0);
      chk("abort_ack", 0, 32'({ack0, ack1}), 32'h0);
      chk("abort_bus", 0, 32'(bd0), 32'hFF);
      reset = 1'b0;
      at_cyc(12);
      chk("abort_no_ack", 0, 32'(ack_cyc0.size()), 32'h0);
      chk("abort_no_ack", 1, 32'(ack_cyc1.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
